// File: rtl/axis_stream_pkg.sv
// Shared definitions for the pixel-inversion stream IP.
// Holds the packetizer state encoding and the default stream/length widths
// that the inverter stage and the frame packetizer agree on.
package axis_stream_pkg;

    localparam int DATA_WIDTH_DEF = 32;   // four packed 8-bit pixels
    localparam int LEN_WIDTH_DEF  = 17;   // frame length up to 131071 words

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pkt_state_e;

    // A frame is in progress from the accepted start until the last word leaves.
    function automatic logic state_is_busy(input pkt_state_e st);
        return (st != IDLE);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer carrying data plus a last tag.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   in_valid        : word offered by the producer (already qualified by it)
//   in_data/in_last : payload and end-of-frame tag of the offered word
//   in_ready        : skid entry empty; depends on registers only
//   out_valid/out_data/out_last : registered output stage
//   out_ready       : consumer ready
// The output register is the first entry, the skid register the second. A
// word arriving while the output is stalled parks in the skid entry, and
// in_ready drops until the skid entry has been moved forward.
module axis_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic             skid_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             skid_last_r;
    logic             in_hs_s;
    logic             out_hs_s;

    // Handshake decode; a full skid entry blocks the input regardless of in_valid.
    always_comb begin
        in_hs_s  = in_valid && !skid_valid_r;
        out_hs_s = out_valid_r && out_ready;
    end

    // Output and skid register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
            skid_last_r  <= 1'b0;
        end else begin
            if (in_hs_s && (!out_valid_r || out_ready)) begin
                // Output stage is free (or emptying this cycle): load directly.
                out_valid_r <= 1'b1;
                out_data_r  <= in_data;
                out_last_r  <= in_last;
            end else if (in_hs_s) begin
                // Output stalled: park the word so in_ready can stay registered.
                skid_valid_r <= 1'b1;
                skid_data_r  <= in_data;
                skid_last_r  <= in_last;
            end else if (out_hs_s && skid_valid_r) begin
                out_data_r   <= skid_data_r;
                out_last_r   <= skid_last_r;
                skid_valid_r <= 1'b0;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = !skid_valid_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: rtl/axis_frame_packetizer.sv
// Frame packetizer between the pixel inverter and the DMA S2MM port.
// Counts a software-armed frame of stream words, tags the final word with
// m_axis_last and forwards everything through a registered skid buffer.
// Ports:
//   axi_clk, axi_reset : clock and synchronous active-high reset
//   start, frame_len   : arm a frame of frame_len words (ignored if busy or 0)
//   busy               : frame in progress (RUN or DRAIN)
//   frame_done         : one-cycle pulse after the last word left
//   word_count         : words delivered on the output this frame
//   s_axis_*           : upstream slave stream from the inverter
//   m_axis_*           : downstream master stream to the DMA
module axis_frame_packetizer
    import axis_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  busy,
    output logic                  frame_done,
    output logic [LEN_WIDTH-1:0]  word_count,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready
);

    pkt_state_e           state_r;
    pkt_state_e           next_state_s;
    logic [LEN_WIDTH-1:0] len_q_r;
    logic [LEN_WIDTH-1:0] in_cnt_r;
    logic [LEN_WIDTH-1:0] word_count_r;
    logic                 frame_done_r;
    logic                 skid_ready_s;
    logic                 start_ok_s;
    logic                 in_hs_s;
    logic                 out_hs_s;
    logic                 in_last_s;

    // Handshake and control decode; s_axis_ready comes from registers only.
    always_comb begin
        start_ok_s   = (state_r == IDLE) && start && (frame_len != {LEN_WIDTH{1'b0}});
        s_axis_ready = (state_r == RUN) && skid_ready_s;
        in_hs_s      = s_axis_valid && s_axis_ready;
        out_hs_s     = m_axis_valid && m_axis_ready;
        in_last_s    = (in_cnt_r == (len_q_r - LEN_WIDTH'(1)));
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (in_hs_s && in_last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if (out_hs_s && m_axis_last) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame length latch, input/output word counters and done pulse.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            len_q_r      <= {LEN_WIDTH{1'b0}};
            in_cnt_r     <= {LEN_WIDTH{1'b0}};
            word_count_r <= {LEN_WIDTH{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_r == DRAIN) && out_hs_s && m_axis_last;
            if (start_ok_s) begin
                len_q_r      <= frame_len;
                in_cnt_r     <= {LEN_WIDTH{1'b0}};
                word_count_r <= {LEN_WIDTH{1'b0}};
            end else begin
                if (in_hs_s) begin
                    in_cnt_r <= in_cnt_r + LEN_WIDTH'(1);
                end
                if (out_hs_s) begin
                    word_count_r <= word_count_r + LEN_WIDTH'(1);
                end
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (axi_clk),
        .rst      (axi_reset),
        .in_valid (in_hs_s),
        .in_data  (s_axis_data),
        .in_last  (in_last_s),
        .in_ready (skid_ready_s),
        .out_valid(m_axis_valid),
        .out_data (m_axis_data),
        .out_last (m_axis_last),
        .out_ready(m_axis_ready)
    );

    assign busy       = state_is_busy(state_r);
    assign frame_done = frame_done_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Self-checking bench for axis_frame_packetizer: directed frames plus a long
// randomized frame, checked against a queue-based reference of the stream.
module tb_axis_frame_packetizer;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        start;
    logic [16:0] frame_len;
    logic        busy;
    logic        frame_done;
    logic [16:0] word_count;
    logic        s_axis_valid;
    logic [31:0] s_axis_data;
    logic        s_axis_ready;
    logic        m_axis_valid;
    logic [31:0] m_axis_data;
    logic        m_axis_last;
    logic        m_axis_ready;

    axis_frame_packetizer dut (
        .axi_clk     (axi_clk),
        .axi_reset   (axi_reset),
        .start       (start),
        .frame_len   (frame_len),
        .busy        (busy),
        .frame_done  (frame_done),
        .word_count  (word_count),
        .s_axis_valid(s_axis_valid),
        .s_axis_data (s_axis_data),
        .s_axis_ready(s_axis_ready),
        .m_axis_valid(m_axis_valid),
        .m_axis_data (m_axis_data),
        .m_axis_last (m_axis_last),
        .m_axis_ready(m_axis_ready)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: words still to offer, words accepted but not yet seen out.
    logic [31:0] src_q[$];
    logic [32:0] exp_q[$];
    int cur_len, acc_cnt, out_cnt, last_cnt, done_cnt;
    bit track_wc = 1'b0;
    bit hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic hold_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe at the falling edge, then return #1 after the rising edge.
    task automatic tick();
        logic ihs, ohs;
        logic [32:0] e;
        @(negedge axi_clk);
        ihs = s_axis_valid && s_axis_ready;
        ohs = m_axis_valid && m_axis_ready;
        if (track_wc) chk("word_count_live", word_count, out_cnt);
        if (hold_pend) begin
            chk("hold_valid", m_axis_valid, 1);
            chk("hold_data", m_axis_data, hold_data);
            chk("hold_last", m_axis_last, hold_last);
        end
        hold_pend = m_axis_valid && !m_axis_ready && !axi_reset;
        hold_data = m_axis_data;
        hold_last = m_axis_last;
        if (ihs === 1'b1) begin
            acc_cnt++;
            exp_q.push_back({(acc_cnt == cur_len), s_axis_data});
            void'(src_q.pop_front());
        end
        if (ohs === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", m_axis_data, e[31:0]);
                chk("out_last", m_axis_last, e[32]);
            end
            if (m_axis_last === 1'b1) last_cnt++;
            out_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
        @(posedge axi_clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit r);
        s_axis_valid = v && (src_q.size() != 0);
        s_axis_data  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        m_axis_ready = r;
        tick();
    endtask

    task automatic start_frame(input int n);
        cur_len  = n;
        acc_cnt  = 0;
        out_cnt  = 0;
        last_cnt = 0;
        done_cnt = 0;
        exp_q.delete();
        track_wc = 1'b0;
        s_axis_valid = 1'b0;
        start = 1'b1;
        frame_len = 17'(n);
        tick();
        start = 1'b0;
        track_wc = 1'b1;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_m_valid"}, m_axis_valid, 0);
        chk({tag, "_m_last"}, m_axis_last, 0);
        chk({tag, "_m_data"}, m_axis_data, 0);
        chk({tag, "_s_ready"}, s_axis_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    // Run random traffic until frame_done, then verify the whole frame.
    task automatic wait_done(input int budget, input int vprob, input int rprob);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            drive(($urandom_range(0, 99) < vprob), ($urandom_range(0, 99) < rprob));
            n++;
        end
        if (done_cnt == 0) chk("frame_timeout", 0, 1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        chk("frame_accepted", acc_cnt, cur_len);
        chk("frame_delivered", out_cnt, cur_len);
        chk("frame_last_count", last_cnt, 1);
        chk("frame_done_count", done_cnt, 1);
        chk("frame_leftover", exp_q.size(), 0);
        chk("frame_word_count", word_count, cur_len);
        chk("frame_busy_end", busy, 0);
    endtask

    initial begin
        axi_reset = 1'b1;
        start = 1'b0;
        frame_len = 17'd0;
        s_axis_valid = 1'b0;
        s_axis_data = 32'h0;
        m_axis_ready = 1'b0;
        cur_len = 0; acc_cnt = 0; out_cnt = 0; last_cnt = 0; done_cnt = 0;
        tick();
        tick();
        axi_reset = 1'b0;
        check_zero("reset");

        // Frame of 4, back-to-back, sink always ready.
        start_frame(4);
        for (int k = 1; k <= 4; k++) src_q.push_back(32'h11111111 * k);
        drive(1'b1, 1'b1);
        chk("latency_valid", m_axis_valid, 1);
        chk("latency_data", m_axis_data, 32'h11111111);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1);
        chk("throughput", out_cnt, 4);
        wait_done(20, 100, 100);

        // Frame of 3, sink stalls 3 cycles after the first word.
        start_frame(3);
        for (int k = 0; k < 3; k++) src_q.push_back($urandom);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        chk("skid_full_ready", s_axis_ready, 0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("stall_accepted", acc_cnt, 2);
        wait_done(30, 100, 100);

        // Frame of 2 with 5 words offered: only 2 accepted.
        start_frame(2);
        for (int k = 0; k < 5; k++) src_q.push_back(32'hA0000000 + k);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("no_overaccept_ready", s_axis_ready, 0);
        wait_done(30, 100, 100);
        chk("upstream_kept", src_q.size(), 3);
        src_q.delete();

        // Zero-length start is ignored.
        done_cnt = 0;
        start = 1'b1;
        frame_len = 17'd0;
        drive(1'b0, 1'b1);
        start = 1'b0;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        chk("zero_len_busy", busy, 0);
        chk("zero_len_done", done_cnt, 0);

        // Start during RUN must not change the frame length.
        start_frame(3);
        for (int k = 0; k < 6; k++) src_q.push_back(32'hC0DE0000 + k);
        drive(1'b1, 1'b1);
        start = 1'b1;
        frame_len = 17'd7;
        drive(1'b1, 1'b1);
        start = 1'b0;
        wait_done(30, 100, 100);
        src_q.delete();

        // Reset after 2 of 8 words accepted, then a 1-word frame.
        start_frame(8);
        for (int k = 0; k < 8; k++) src_q.push_back($urandom);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("pre_reset_accepted", acc_cnt, 2);
        track_wc = 1'b0;
        axi_reset = 1'b1;
        drive(1'b0, 1'b0);
        axi_reset = 1'b0;
        check_zero("mid_reset");
        src_q.delete();
        start_frame(1);
        src_q.push_back(32'hDEADBEEF);
        wait_done(20, 100, 100);

        // Long randomized frame.
        start_frame(1000);
        for (int k = 0; k < 1000; k++) src_q.push_back($urandom);
        wait_done(20000, 70, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
